ifm_bram_pingpong: RTL and testbench
====================================

Name: ifm_bram_pingpong

Overview:
- Double-buffered IFM store: two identical BRAM banks with per-bank FREE/FULL ownership state.
- The IFM loader fills one bank while the PE array reads the previously filled bank.
- Read addresses arrive as byte addresses and are shifted down to word indices.
- Adds bank handshakes, a configurable read latency with data_valid, and out-of-range error reporting.

Parameters:
DATA_W, 32, word width of each bank entry and of data_in/data_out
DEPTH, 26912, words per bank
WR_ADDR_W, 32, write address width (word index)
RD_ADDR_W, 20, read address width (byte address)
RD_SHIFT, 2, right shift applied to rd_addr to form the word index
OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for latency 2

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe into the current write bank
wr_addr  input  WR_ADDR_W  word index of the write
data_in  input  DATA_W  write data
wr_done  input  1  pulse: close the current write bank (mark FULL) and advance to the other bank
rd_en  input  1  read strobe from the current read bank
rd_addr  input  RD_ADDR_W  byte address of the read
rd_done  input  1  pulse: release the current read bank (mark FREE) and advance to the other bank
data_out  output  DATA_W  read data
data_valid  output  1  data_out holds the result of an accepted read
wr_ready  output  1  current write bank is FREE
rd_ready  output  1  current read bank is FULL
wr_bank  output  1  index of the current write bank
rd_bank  output  1  index of the current read bank
err  output  2  sticky flags: bit0 = write rejected (bank not FREE or address out of range); bit1 = read rejected (bank not FULL or address out of range)

Behaviour:
- Reset (async, rst=1): both banks FREE; wr_bank=0, rd_bank=0; data_out=0; data_valid=0; err=0; pipeline flushed. Memory contents are not cleared.
- Combinational status: wr_ready = (state[wr_bank]==FREE); rd_ready = (state[rd_bank]==FULL).
- Write accept: wr_en & wr_ready & (wr_addr < DEPTH) -> bank[wr_bank][wr_addr] <= data_in at the clock edge.
- Write reject: wr_en with either condition false -> no memory change; err[0] <= 1.
- wr_done:
  - Ignored if wr_ready=0.
  - Otherwise state[wr_bank] <= FULL and wr_bank toggles.
  - A write in the same cycle is committed to the old bank before it closes.
- Read index: idx = rd_addr >> RD_SHIFT.
- Read accept: rd_en & rd_ready & (idx < DEPTH).
  - OUT_REG=0: data_out = bank[rd_bank][idx] and data_valid=1 one cycle later.
  - OUT_REG=1: same, two cycles later.
  - Back-to-back reads give one result per cycle.
- Read reject: rd_en with either condition false -> err[1] <= 1; no valid pulse for that request.
- No accepted read in the matching slot: data_valid=0 and data_out holds its last value.
- rd_done:
  - Ignored if rd_ready=0.
  - Otherwise state[rd_bank] <= FREE and rd_bank toggles.
  - A read accepted in the same cycle still completes with the correct (old-bank) data.
- Concurrency:
  - wr_done and rd_done in the same cycle act on different banks; both apply.
  - When both banks are FULL, wr_ready=0 until a rd_done.
  - When both banks are FREE, rd_ready=0.
- Bank pointers are 1 bit and wrap 1->0 naturally.
- No read/write collision is possible: a bank is either writer-owned (FREE) or reader-owned (FULL).
- err bits clear only on rst.
- Reset asserted mid-read: in-flight results are discarded and data_valid=0 immediately.

Test Plan:
1. Reset, write 0xA0000000+i to addr i=0..7, wr_done; read rd_addr=4*i -> rd_ready=1, data_out=0xA0000000+i, data_valid exactly 1 cycle after each rd_en (OUT_REG=0) and 2 cycles after (OUT_REG=1).
2. Ping-pong: fill bank0 with 0x11, wr_done, fill bank1 with 0x22 while reading bank0 -> reads return 0x11; after rd_done, reads return 0x22, wr_bank=0, rd_bank=1->0 sequence correct.
3. Both banks FULL, wr_en addr 3 data 0xDEAD -> wr_ready=0, err=2'b01, later read of addr 3 unchanged.
4. Out of range: wr_addr=26912 and rd_addr=4*26912 -> no write, no valid, err=2'b11.
5. rd_done and wr_done in the same cycle with rd_en on idx 5 -> data_out=bank value at idx 5, both bank states update, pointers both toggle.
6. Assert rst one cycle after rd_en with OUT_REG=1 -> data_valid stays 0, data_out=0, wr_ready=1, rd_ready=0.

Source files
------------

// File: rtl/ifm_bram_pingpong.sv
// Double-buffered IFM store: two BRAM banks handed back and forth between the
// IFM loader (writer) and the PE array (reader) via per-bank FREE/FULL state.
module ifm_bram_pingpong #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 26912,
  parameter int WR_ADDR_W = 32,
  parameter int RD_ADDR_W = 20,
  parameter int RD_SHIFT  = 2,
  parameter int OUT_REG   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WR_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr_done,
  input  logic                 rd_en,
  input  logic [RD_ADDR_W-1:0] rd_addr,
  input  logic                 rd_done,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 wr_ready,
  output logic                 rd_ready,
  output logic                 wr_bank,
  output logic                 rd_bank,
  output logic [1:0]           err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // state bit set means the bank is FULL (reader-owned)
  logic [1:0]        state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        err_q, err_d;
  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic              sel_q, sel_d;
  logic              have_q, have_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic [RD_ADDR_W-1:0] rd_word_idx;
  logic                 wr_in_range, rd_in_range;
  logic                 wr_acc, rd_acc;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic [DATA_W-1:0]    bank_rd [2];
  logic [DATA_W-1:0]    rd_mux;

  assign rd_word_idx = rd_addr >> RD_SHIFT;
  assign wr_in_range = (wr_addr < WR_ADDR_W'(DEPTH));
  assign rd_in_range = (rd_word_idx < RD_ADDR_W'(DEPTH));
  assign wr_ready    = ~state_q[wr_bank_q];
  assign rd_ready    = state_q[rd_bank_q];
  assign wr_acc      = wr_en & wr_ready & wr_in_range;
  assign rd_acc      = rd_en & rd_ready & rd_in_range;
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_word_idx[IDX_W-1:0];
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign err         = err_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk) begin
        if (wr_acc && (wr_bank_q == 1'(gi))) begin
          mem[wr_idx] <= data_in;
        end
        if (rd_acc && (rd_bank_q == 1'(gi))) begin
          rd_q <= mem[rd_idx];
        end
      end

      assign bank_rd[gi] = rd_q;
    end
  endgenerate

  // each bank's read register only moves on its own reads, so muxing by the
  // last-read bank naturally holds data_out between accepted reads
  assign rd_mux = bank_rd[sel_q];

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_done && wr_ready) begin
      state_d[wr_bank_q] = 1'b1;
      wr_bank_d          = ~wr_bank_q;
    end
    if (rd_done && rd_ready) begin
      state_d[rd_bank_q] = 1'b0;
      rd_bank_d          = ~rd_bank_q;
    end
    err_d  = err_q | {rd_en & ~rd_acc, wr_en & ~wr_acc};
    v1_d   = rd_acc;
    sel_d  = rd_acc ? rd_bank_q : sel_q;
    have_d = have_q | rd_acc;
    v2_d   = v1_q;
    out_d  = v1_q ? rd_mux : out_q;
  end

  always_comb begin
    data_out   = '0;
    data_valid = 1'b0;
    if (OUT_REG != 0) begin
      data_out   = out_q;
      data_valid = v2_q;
    end else begin
      data_out   = have_q ? rd_mux : '0;
      data_valid = v1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      err_q     <= 2'b00;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      sel_q     <= 1'b0;
      have_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      err_q     <= err_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      sel_q     <= sel_d;
      have_q    <= have_d;
      out_q     <= out_d;
    end
  end

endmodule

// File: tb/tb_ifm_bram_pingpong.sv
// Scoreboard bench: two DUTs (read latency 1 and 2) share stimulus; expected
// read data is queued at issue time and popped by per-DUT monitors.
module tb_ifm_bram_pingpong;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [31:0] wr_addr = '0, data_in = '0;
  logic [19:0] rd_addr = '0;

  logic [31:0] do0, do1;
  logic        dv0, dv1, wrr0, wrr1, rdr0, rdr1, wb0, wb1, rb0, rb1;
  logic [1:0]  err0, err1;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifm_bram_pingpong #(.OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
    .wr_done(wr_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .data_out(do0), .data_valid(dv0), .wr_ready(wrr0), .rd_ready(rdr0),
    .wr_bank(wb0), .rd_bank(rb0), .err(err0)
  );

  ifm_bram_pingpong #(.OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
    .wr_done(wr_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .data_out(do1), .data_valid(dv1), .wr_ready(wrr1), .rd_ready(rdr1),
    .wr_bank(wb1), .rd_bank(rb1), .err(err1)
  );

  always @(negedge clk) begin
    if (dv0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL lat1_unexpected_valid cyc=%0d data_out=%h, required no valid", cyc, do0);
      end else begin
        e0 = q0.pop_front();
        if (do0 !== e0.d || cyc != e0.due) begin
          n_err++;
          $display("FAIL lat1_read got %h at cyc %0d, required %h at cyc %0d", do0, cyc, e0.d, e0.due);
        end else
          $display("lat1 read %h at cyc %0d ok", do0, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (dv1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL lat2_unexpected_valid cyc=%0d data_out=%h, required no valid", cyc, do1);
      end else begin
        e1 = q1.pop_front();
        if (do1 !== e1.d || cyc != e1.due) begin
          n_err++;
          $display("FAIL lat2_read got %h at cyc %0d, required %h at cyc %0d", do1, cyc, e1.d, e1.due);
        end else
          $display("lat2 read %h at cyc %0d ok", do1, cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h, required %h", nm, act, exp);
    end else
      $display("check %s = %h ok", nm, act);
  endtask

  task automatic op(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                    input logic wdn, input logic re, input logic [19:0] ra,
                    input logic rdn, input logic racc, input logic [31:0] rexp);
    wr_en   = we;
    wr_addr = wa;
    data_in = wd;
    wr_done = wdn;
    rd_en   = re;
    rd_addr = ra;
    rd_done = rdn;
    if (racc) begin
      q0.push_back('{rexp, cyc + 1});
      q1.push_back('{rexp, cyc + 2});
    end
    step();
    wr_en   = 1'b0;
    wr_done = 1'b0;
    rd_en   = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // 1: reset state, fill bank0, back-to-back reads
    do_reset();
    chk("rst_wr_ready", 32'(wrr0), 32'd1);
    chk("rst_rd_ready", 32'(rdr0), 32'd0);
    chk("rst_wr_bank", 32'(wb0), 32'd0);
    chk("rst_rd_bank", 32'(rb0), 32'd0);
    chk("rst_valid_lat1", 32'(dv0), 32'd0);
    chk("rst_valid_lat2", 32'(dv1), 32'd0);
    chk("rst_dout_lat1", do0, 32'd0);
    chk("rst_dout_lat2", do1, 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    for (int i = 0; i < 8; i++) op(1, 32'(i), 32'hA000_0000 + 32'(i), 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("t1_wr_bank", 32'(wb0), 32'd1);
    chk("t1_rd_bank", 32'(rb0), 32'd0);
    chk("t1_rd_ready", 32'(rdr0), 32'd1);
    chk("t1_wr_ready", 32'(wrr0), 32'd1);
    for (int i = 0; i < 8; i++) op(0, 0, 0, 0, 1, 20'(4 * i), 0, 1, 32'hA000_0000 + 32'(i));
    idle(3);

    // 2: ping-pong, writer fills bank1 while reader drains bank0
    do_reset();
    for (int i = 0; i < 4; i++) op(1, 32'(i), 32'h1100 + 32'(i), 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      op(1, 32'(i), 32'h2200 + 32'(i), 0, 1, 20'(4 * i), 0, 1, 32'h1100 + 32'(i));
    op(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("t2_wr_bank_wrap", 32'(wb0), 32'd0);
    chk("t2_wr_ready_full", 32'(wrr0), 32'd0);
    op(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t2_rd_bank", 32'(rb0), 32'd1);
    chk("t2_wr_ready_freed", 32'(wrr0), 32'd1);
    for (int i = 0; i < 4; i++) op(0, 0, 0, 0, 1, 20'(4 * i), 0, 1, 32'h2200 + 32'(i));
    op(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t2_rd_bank_wrap", 32'(rb0), 32'd0);
    chk("t2_rd_ready_empty", 32'(rdr0), 32'd0);
    idle(3);

    // 3: both banks full, write rejected
    op(1, 3, 32'h33, 1, 0, 0, 0, 0, 0);
    op(1, 3, 32'h44, 1, 0, 0, 0, 0, 0);
    chk("t3_wr_ready", 32'(wrr0), 32'd0);
    chk("t3_err_before", 32'(err0), 32'd0);
    op(1, 3, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    chk("t3_err_wr", 32'(err0), 32'd1);
    op(0, 0, 0, 0, 1, 20'd12, 0, 1, 32'h33);
    op(0, 0, 0, 0, 0, 0, 1, 0, 0);
    op(0, 0, 0, 0, 1, 20'd12, 0, 1, 32'h44);
    idle(3);
    chk("t3_err_after", 32'(err1), 32'd1);

    // 4: last valid index, byte-offset address, out-of-range rejects
    do_reset();
    op(1, 32'd26911, 32'h5A5A_5A5A, 1, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 20'd107644, 0, 1, 32'h5A5A_5A5A);
    op(0, 0, 0, 0, 1, 20'd11, 0, 1, 32'h1102);
    idle(3);
    chk("t4_err_none", 32'(err0), 32'd0);
    op(1, 32'd26912, 32'hBAD, 0, 0, 0, 0, 0, 0);
    chk("t4_err_wr", 32'(err0), 32'd1);
    op(0, 0, 0, 0, 1, 20'd107648, 0, 0, 0);
    idle(3);
    chk("t4_err_both", 32'(err0), 32'd3);

    // 5: wr_done and rd_done together, with write and read in the same cycle
    op(1, 5, 32'h55, 0, 0, 0, 0, 0, 0);
    op(1, 6, 32'h66, 1, 1, 20'd20, 1, 1, 32'hA000_0005);
    chk("t5_wr_bank", 32'(wb0), 32'd0);
    chk("t5_rd_bank", 32'(rb0), 32'd1);
    chk("t5_wr_ready", 32'(wrr0), 32'd1);
    chk("t5_rd_ready", 32'(rdr0), 32'd1);
    op(0, 0, 0, 0, 1, 20'd24, 0, 1, 32'h66);
    op(0, 0, 0, 0, 1, 20'd20, 0, 1, 32'h55);
    idle(3);
    chk("t5_err", 32'(err0), 32'd3);

    // 6: reset while a latency-2 read is in flight
    do_reset();
    op(0, 0, 0, 1, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 20'd0, 0, 1, 32'h1100);
    rst = 1'b1;
    q1.delete();
    #1;
    chk("t6_valid_lat2", 32'(dv1), 32'd0);
    chk("t6_dout_lat2", do1, 32'd0);
    chk("t6_dout_lat1", do0, 32'd0);
    chk("t6_wr_ready", 32'(wrr1), 32'd1);
    chk("t6_rd_ready", 32'(rdr1), 32'd0);
    step();
    rst = 1'b0;
    idle(4);
    chk("end_q_lat1_empty", 32'(q0.size()), 32'd0);
    chk("end_q_lat2_empty", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
